// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator APB initiator: FSM encoding and slave register map.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [12:0] ACC_EN_ADDR     = 13'h1FF0;
  localparam logic [12:0] ACC_LOAD_A_ADDR = 13'h1FF4;
  localparam logic [12:0] ACC_LOAD_X_ADDR = 13'h1FF8;
  localparam logic [31:0] ACC_EN_VALUE    = 32'd1;
  localparam logic [31:0] ACC_END_VALUE   = 32'd0;

  // Byte stride between consecutive 32-bit beats of a burst.
  localparam int APB_ADDR_INC = 4;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Purpose: counts APB ACCESS cycles and flags when the PREADY wait budget is spent.
// Latency: expired is combinational from the count, high during the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; TIMEOUT_CYCLES=0 keeps expired low forever.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/apb_acc_master.sv
// Purpose: turns a valid/ready command stream into APB SETUP/ACCESS beats, one response per beat.
// Latency: response valid 3 cycles after command handshake with PREADY high; 3 cycles/beat in bursts.
// Backpressure: cmd_ready only in IDLE; a stalled response holds its payload and blocks the next beat.
module apb_acc_master
  import acc_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 13,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  input  logic [7:0]                cmd_len,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_last,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_INC = APB_ADDR_WIDTH'(APB_ADDR_INC);

  state_t     state;
  logic [7:0] beats_left;
  logic       tmo_expired;

  assign cmd_ready = (state == ST_IDLE);

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .clr    (state == ST_SETUP),
    .en     (state == ST_ACCESS),
    .expired(tmo_expired)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      beats_left <= 8'd0;
      busy       <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      rsp_last   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state      <= ST_SETUP;
            busy       <= 1'b1;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            PADDR      <= cmd_addr;
            PWRITE     <= cmd_write;
            beats_left <= cmd_write ? 8'd0 : cmd_len;
            if (cmd_write) begin
              PWDATA <= cmd_wdata;
            end
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          // A completing PREADY wins over a timeout landing on the same cycle.
          if (PREADY) begin
            state     <= ST_RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
            rsp_err   <= PSLVERR;
            rsp_last  <= PSLVERR || (beats_left == 8'd0);
          end else if (tmo_expired) begin
            state     <= ST_RESP;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            // rsp_last already folds in errors, so it alone decides whether the burst continues.
            if (!rsp_last) begin
              state      <= ST_SETUP;
              PSEL       <= 1'b1;
              PADDR      <= PADDR + ADDR_INC;
              beats_left <= beats_left - 8'd1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_acc_master.sv
// Directed bench for apb_acc_master: single-beat vector table plus burst, stall, error, timeout and reset sequences.
module tb_apb_acc_master;
  import acc_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [12:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;
  logic [12:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model: wait_n low ACCESS cycles before PREADY, optional error on absolute beat err_beat.
  int wait_n = 0;
  bit never_ready = 1'b0;
  int err_beat = -1;
  int acc_cnt = 0;
  int beat_num = 0;
  logic [12:0] setup_q[$];
  logic [31:0] got_rdata[$];
  logic        got_err[$];
  logic        got_last[$];

  always #5 HCLK = ~HCLK;

  apb_acc_master #(
    .APB_ADDR_WIDTH(13),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  assign PREADY  = !never_ready && (acc_cnt >= wait_n);
  assign PSLVERR = PSEL && PENABLE && (beat_num == err_beat);
  assign PRDATA  = {19'd0, PADDR} | 32'hA500;

  always @(posedge HCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY) beat_num <= beat_num + 1;
    if (PSEL && !PENABLE) setup_q.push_back(PADDR);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Returns one cycle after the handshake edge (cycle N+1).
  task automatic issue(input logic wr, input logic [12:0] addr, input logic [31:0] wd, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Accepts responses with rsp_ready held high until a last beat or the cycle budget runs out.
  task automatic collect(input int max_cyc);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    got_rdata.delete();
    got_err.delete();
    got_last.delete();
    rsp_ready = 1'b1;
    while (!done && c < max_cyc) begin
      if (rsp_valid) begin
        got_rdata.push_back(rsp_rdata);
        got_err.push_back(rsp_err);
        got_last.push_back(rsp_last);
        if (rsp_last) done = 1'b1;
      end
      tick();
      c++;
    end
    rsp_ready = 1'b0;
    chk("collect_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    int          waitn;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int stable_cnt;
    int bad;
    int nvalid;

    vecs[0] = '{1'b1, ACC_EN_ADDR,     ACC_EN_VALUE,  0, 32'h0,      3};
    vecs[1] = '{1'b0, 13'h0010,        32'h0,         0, 32'h0000A510, 3};
    vecs[2] = '{1'b1, ACC_LOAD_X_ADDR, ACC_END_VALUE, 2, 32'h0,      5};
    vecs[3] = '{1'b0, ACC_EN_ADDR,     32'h0,         1, 32'h0000BFF0, 4};

    repeat (3) tick();
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_penable", 32'(PENABLE), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    HRESETn = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 1);

    // Single-beat table: phase timing, latency and payload.
    for (int i = 0; i < 4; i++) begin
      wait_n = vecs[i].waitn;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 8'd0);
      chk($sformatf("v%0d_setup_psel", i), 32'(PSEL), 1);
      chk($sformatf("v%0d_setup_penable", i), 32'(PENABLE), 0);
      chk($sformatf("v%0d_cmd_ready_busy", i), 32'(cmd_ready), 0);
      lat = 1;
      while (!rsp_valid && lat < 60) begin
        tick();
        lat++;
        if (lat == 2) chk($sformatf("v%0d_access_penable", i), 32'(PENABLE), 1);
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(rsp_err), 0);
      chk($sformatf("v%0d_last", i), 32'(rsp_last), 1);
      chk($sformatf("v%0d_paddr", i), 32'(PADDR), 32'(vecs[i].addr));
      chk($sformatf("v%0d_psel_dropped", i), 32'(PSEL), 0);
      if (vecs[i].wr) chk($sformatf("v%0d_pwdata", i), PWDATA, vecs[i].wdata);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_done", i), 32'(rsp_valid), 0);
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
    end
    wait_n = 0;

    // Read burst of 4 from 0x000.
    setup_q.delete();
    issue(1'b0, 13'h000, 32'h0, 8'd3);
    collect(40);
    chk("burst_nbeats", 32'(got_rdata.size()), 4);
    for (int b = 0; b < 4 && b < got_rdata.size(); b++) begin
      chk($sformatf("burst_rdata%0d", b), got_rdata[b], 32'hA500 + 32'(4 * b));
      chk($sformatf("burst_last%0d", b), 32'(got_last[b]), (b == 3) ? 32'd1 : 32'd0);
      chk($sformatf("burst_err%0d", b), 32'(got_err[b]), 0);
    end
    chk("burst_nsetup", 32'(setup_q.size()), 4);
    for (int b = 0; b < 4 && b < setup_q.size(); b++)
      chk($sformatf("burst_paddr%0d", b), 32'(setup_q[b]), 32'(4 * b));

    // PREADY held low for 5 ACCESS cycles: bus must stay frozen.
    wait_n = 5;
    issue(1'b1, ACC_LOAD_A_ADDR, 32'hDEADBEEF, 8'd0);
    stable_cnt = 0;
    bad = 0;
    for (int c = 0; c < 20 && !rsp_valid; c++) begin
      if (!PSEL || PADDR !== ACC_LOAD_A_ADDR || PWDATA !== 32'hDEADBEEF || !PWRITE) bad++;
      if (PENABLE) stable_cnt++;
      tick();
    end
    chk("wait_bus_unstable", 32'(bad), 0);
    chk("wait_access_cycles", 32'(stable_cnt), 6);
    collect(5);
    chk("wait_nrsp", 32'(got_err.size()), 1);
    if (got_err.size() > 0) chk("wait_err", 32'(got_err[0]), 0);
    wait_n = 0;

    // Timeout: no PREADY at all.
    never_ready = 1'b1;
    issue(1'b0, 13'h0020, 32'h0, 8'd0);
    stable_cnt = 0;
    for (int c = 0; c < 40 && !rsp_valid; c++) begin
      if (PSEL && PENABLE) stable_cnt++;
      tick();
    end
    chk("tmo_access_cycles", 32'(stable_cnt), 16);
    chk("tmo_psel", 32'(PSEL), 0);
    chk("tmo_err", 32'(rsp_err), 1);
    chk("tmo_last", 32'(rsp_last), 1);
    chk("tmo_rdata", rsp_rdata, 0);
    collect(3);
    never_ready = 1'b0;
    chk("tmo_back_idle", 32'(cmd_ready), 1);

    // PSLVERR on second beat aborts the rest of the burst.
    setup_q.delete();
    err_beat = beat_num + 1;
    issue(1'b0, 13'h0100, 32'h0, 8'd3);
    collect(30);
    repeat (6) tick();
    err_beat = -1;
    chk("err_nrsp", 32'(got_err.size()), 2);
    if (got_err.size() == 2) begin
      chk("err_beat0_err", 32'(got_err[0]), 0);
      chk("err_beat0_last", 32'(got_last[0]), 0);
      chk("err_beat1_err", 32'(got_err[1]), 1);
      chk("err_beat1_last", 32'(got_last[1]), 1);
    end
    chk("err_nsetup", 32'(setup_q.size()), 2);

    // Address wraps at the top of the window.
    setup_q.delete();
    issue(1'b0, 13'h1FFC, 32'h0, 8'd1);
    collect(20);
    chk("wrap_nsetup", 32'(setup_q.size()), 2);
    if (setup_q.size() == 2) chk("wrap_paddr1", 32'(setup_q[1]), 0);
    if (got_rdata.size() == 2) chk("wrap_rdata1", got_rdata[1], 32'hA500);

    // Response stalled for 10 cycles mid-burst.
    setup_q.delete();
    issue(1'b0, 13'h0040, 32'h0, 8'd2);
    for (int c = 0; c < 20 && !rsp_valid; c++) tick();
    chk("stall_first_valid", 32'(rsp_valid), 1);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== 32'hA540 || rsp_last || rsp_err) bad++;
    end
    chk("stall_payload_unstable", 32'(bad), 0);
    chk("stall_nsetup", 32'(setup_q.size()), 1);
    collect(30);
    chk("stall_nbeats", 32'(got_rdata.size()), 3);
    for (int b = 0; b < 3 && b < got_rdata.size(); b++)
      chk($sformatf("stall_rdata%0d", b), got_rdata[b], 32'hA540 + 32'(4 * b));

    // Reset asserted during ACCESS abandons the beat.
    setup_q.delete();
    wait_n = 20;
    issue(1'b1, 13'h0030, 32'h12345678, 8'd0);
    tick();
    chk("rstx_in_access", 32'(PENABLE), 1);
    HRESETn = 1'b0;
    tick();
    chk("rstx_psel", 32'(PSEL), 0);
    chk("rstx_penable", 32'(PENABLE), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_cmd_ready", 32'(cmd_ready), 1);
    chk("rstx_pwdata", PWDATA, 0);
    HRESETn = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) nvalid++;
      tick();
    end
    chk("rstx_no_rsp", 32'(nvalid), 0);
    chk("rstx_no_retry", 32'(setup_q.size()), 1);
    wait_n = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
